// File: rtl/nv_nvdla_pdp_layer_seq.sv
// PDP layer sequencer: selects the SDP (on-flying) or RDMA (off-flying) beat
//   source for one layer, registers the beats towards the NaN/preproc stage,
//   detects the layer-end beat and reports completion plus the beat count.
// Latency: 1 cycle from source accept to dp_pvld; full throughput, 1 beat/clk.
// Backpressure: the selected source is ready only in RUN and only while the
//   output register is empty or draining this cycle; dp_pd/dp_pvld hold under stall.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rst  clock, async active-high reset
//   reg2dp_op_en                     layer enable level (rising edge starts a layer)
//   reg2dp_flying_mode               0 = SDP source, 1 = RDMA source (latched per layer)
//   sdp2pdp_*                        on-flying source valid/ready/payload
//   rdma2dp_*                        off-flying source valid/ready/payload
//   dp_pvld / dp_prdy / dp_pd        registered downstream stream
//   layer_done                       one-cycle pulse when the layer has drained
//   dp2reg_beat_num                  beat count of the last completed layer
//   seq_busy                         high whenever the sequencer is not idle
module nv_nvdla_pdp_layer_seq #(
  parameter int PD_W  = 78,
  parameter int CNT_W = 32
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             reg2dp_op_en,
  input  logic             reg2dp_flying_mode,
  input  logic             sdp2pdp_valid,
  output logic             sdp2pdp_ready,
  input  logic [PD_W-1:0]  sdp2pdp_pd,
  input  logic             rdma2dp_valid,
  output logic             rdma2dp_ready,
  input  logic [PD_W-1:0]  rdma2dp_pd,
  output logic             dp_pvld,
  input  logic             dp_prdy,
  output logic [PD_W-1:0]  dp_pd,
  output logic             layer_done,
  output logic [CNT_W-1:0] dp2reg_beat_num,
  output logic             seq_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q,    state_d;
  logic              op_en_d1_q, op_en_d1_d;
  logic              mode_q,     mode_d;
  logic              pending_q,  pending_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [CNT_W-1:0]  beat_num_q, beat_num_d;
  logic              pvld_q,     pvld_d;
  logic [PD_W-1:0]   pd_q,       pd_d;

  logic              op_en_rise;
  logic              src_rdy;
  logic              sel_vld;
  logic [PD_W-1:0]   sel_pd;
  logic              accept;
  logic              layer_end;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign op_en_rise = reg2dp_op_en & ~op_en_d1_q;

  // Output register can take a beat when empty or when it empties this cycle.
  assign src_rdy   = (~pvld_q | dp_prdy) & (state_q == RUN);
  assign sel_vld   = mode_q ? rdma2dp_valid : sdp2pdp_valid;
  assign sel_pd    = mode_q ? rdma2dp_pd    : sdp2pdp_pd;
  assign accept    = sel_vld & src_rdy;
  // cube_end & layer_end flags of the info field
  assign layer_end = accept & sel_pd[PD_W-1] & sel_pd[PD_W-5];

  always_comb begin
    state_d    = state_q;
    op_en_d1_d = reg2dp_op_en;
    mode_d     = mode_q;
    pending_d  = pending_q;
    cnt_d      = cnt_q;
    beat_num_d = beat_num_q;
    pvld_d     = pvld_q;
    pd_d       = pd_q;

    // Output register: load on accept, otherwise empty once consumed.
    if (accept) begin
      pvld_d = 1'b1;
      pd_d   = sel_pd;
    end else if (dp_prdy) begin
      pvld_d = 1'b0;
    end

    // Saturating beat counter.
    if (accept && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    case (state_q)
      IDLE: begin
        if (op_en_rise) begin
          mode_d  = reg2dp_flying_mode;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (op_en_rise) pending_d = 1'b1;
        if (layer_end)  state_d   = DRAIN;
      end
      DRAIN: begin
        if (op_en_rise) pending_d = 1'b1;
        if (~pvld_q | dp_prdy) state_d = DONE;
      end
      DONE: begin
        beat_num_d = cnt_q;
        // A rise arriving in DONE itself also chains into the next layer.
        if (pending_q | op_en_rise) begin
          pending_d = 1'b0;
          mode_d    = reg2dp_flying_mode;
          cnt_d     = '0;
          state_d   = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q    <= IDLE;
      op_en_d1_q <= 1'b0;
      mode_q     <= 1'b0;
      pending_q  <= 1'b0;
      cnt_q      <= '0;
      beat_num_q <= '0;
      pvld_q     <= 1'b0;
      pd_q       <= '0;
    end else begin
      state_q    <= state_d;
      op_en_d1_q <= op_en_d1_d;
      mode_q     <= mode_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      beat_num_q <= beat_num_d;
      pvld_q     <= pvld_d;
      pd_q       <= pd_d;
    end
  end

  assign sdp2pdp_ready   = src_rdy & ~mode_q;
  assign rdma2dp_ready   = src_rdy &  mode_q;
  assign dp_pvld         = pvld_q;
  assign dp_pd           = pd_q;
  assign layer_done      = (state_q == DONE);
  assign dp2reg_beat_num = beat_num_q;
  assign seq_busy        = (state_q != IDLE);

endmodule

// File: doc/nv_nvdla_pdp_layer_seq.md
NV_NVDLA_PDP_LAYER_SEQ -- requirements
Module: NV_NVDLA_PDP_layer_seq

Interface
REQ-001 SHALL have parameter PD_W, default 78, giving the beat payload width (64 data bits plus 14 info bits).
REQ-002 SHALL have parameter CNT_W, default 32, giving the width of the beat counter and status register.
REQ-003 SHALL have nvdla_core_clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-004 SHALL have nvdla_core_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have reg2dp_op_en, input, 1 bit: layer enable level; only its rising edge is used.
REQ-006 SHALL have reg2dp_flying_mode, input, 1 bit: 0 selects on-flying (SDP) source, 1 selects off-flying (RDMA) source.
REQ-007 SHALL have sdp2pdp_valid (input, 1), sdp2pdp_ready (output, 1) and sdp2pdp_pd (input, PD_W): on-flying source port.
REQ-008 SHALL have rdma2dp_valid (input, 1), rdma2dp_ready (output, 1) and rdma2dp_pd (input, PD_W): off-flying source port.
REQ-009 SHALL have dp_pvld (output, 1), dp_prdy (input, 1) and dp_pd (output, PD_W): the downstream stream into the NaN/preproc stage.
REQ-010 SHALL have layer_done, output, 1 bit: one-cycle pulse when a layer fully drains.
REQ-011 SHALL have dp2reg_beat_num, output, CNT_W bits: beat count of the last completed layer.
REQ-012 SHALL have seq_busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-014 SHALL compute op_en_rise = reg2dp_op_en & ~op_en_d1, where op_en_d1 is a registered copy of reg2dp_op_en.
REQ-015 SHALL, in IDLE on op_en_rise, latch reg2dp_flying_mode into mode_q, clear the beat counter, and enter RUN on the next cycle.
REQ-016 SHALL drive the selected source's ready as (~dp_pvld | dp_prdy) & (state==RUN).
- The non-selected source's ready SHALL be 0 in every state.
REQ-017 SHALL load dp_pd from the selected source and set dp_pvld on an accept (valid & ready).
- dp_pvld SHALL clear when dp_prdy=1 and no new accept occurs.
- Latency: 1 cycle; a full-throughput bubble-free stream SHALL pass at one beat per clock.
REQ-018 SHALL identify the layer-end beat as pd[PD_W-1] & pd[PD_W-5] (cube_end & layer_end) on an accepted beat.
REQ-019 SHALL increment the beat counter on every accepted beat, including the layer-end beat.
- The counter SHALL saturate at all-ones with no wrap.
REQ-020 SHALL move from RUN to DRAIN on the cycle the layer-end beat is accepted.
- From that cycle on, both source readies SHALL be 0.
REQ-021 SHALL move from DRAIN to DONE when dp_pvld=0, or when dp_pvld & dp_prdy occurs.
- DONE SHALL last exactly one cycle.
REQ-022 SHALL, in DONE, pulse layer_done=1 and copy the beat counter into dp2reg_beat_num.
REQ-023 SHALL set a pending flag on an op_en_rise seen in RUN, DRAIN or DONE; a second rise while pending SHALL be ignored.
REQ-024 SHALL, on leaving DONE with pending=1, clear pending, re-sample reg2dp_flying_mode, clear the counter and enter RUN directly.
- With pending=0, DONE SHALL exit to IDLE.
REQ-025 SHALL keep mode_q fixed between layers; a change of reg2dp_flying_mode mid-layer SHALL have no effect.
REQ-026 SHALL hold dp_pd and dp_pvld stable while dp_pvld=1 and dp_prdy=0.

Reset
REQ-027 SHALL, on nvdla_core_rst=1 asserted at any time including mid-layer, immediately force:
- state=IDLE, dp_pvld=0, dp_pd=0, both source readies=0;
- layer_done=0, seq_busy=0, dp2reg_beat_num=0;
- counter=0, pending=0, mode_q=0, op_en_d1=0.
REQ-028 SHALL treat reg2dp_op_en held high across reset release as a rise on the first clock after release.

Verification
REQ-029 SHALL cover an off-fly layer: flying_mode=1, op_en rises, RDMA sends 4 beats with the 4th carrying bits 77 and 73 set, dp_prdy=1 -> 4 beats out with 1-cycle latency, sdp2pdp_ready=0 throughout, layer_done pulses once, dp2reg_beat_num=4.
REQ-030 SHALL cover backpressure: dp_prdy=0 for 5 cycles mid-layer -> rdma2dp_ready=0, dp_pd unchanged, no beat lost or duplicated.
REQ-031 SHALL cover back-to-back layers: op_en re-rises during DRAIN with flying_mode=0 -> after layer_done the next layer runs from SDP with no IDLE cycle, and the beat count restarts from 0.
REQ-032 SHALL cover mid-layer reset: reset asserted after 2 of 6 beats -> all outputs zero the same cycle; after release a fresh op_en rise runs a clean layer.
REQ-033 SHALL cover the layer-end beat stalled in the output register: dp_prdy=0 for 3 cycles -> state stays DRAIN, and layer_done comes 1 cycle after the handshake.
REQ-034 SHALL cover the idle guard: valid asserted on both sources while IDLE -> both readies stay 0, and dp_pvld stays 0.
